// File: rtl/sock_line_responder.sv
// sock_line_responder: parses newline-terminated ASCII register commands
// ("W addr data" / "R addr") from a byte stream, runs one bus transaction
// per command and answers with exactly one ASCII response line.
module sock_line_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  localparam int NA   = ADDR_W / 4;
  localparam int ND   = DATA_W / 4;
  localparam int MAXD = (NA > ND) ? NA : ND;
  localparam int CW   = $clog2(MAXD + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int IW   = $clog2(ND + 2);

  typedef enum logic [2:0] {
    IDLE, SEP1, ADDR, SEP2, DATA, DISCARD, REQ, RESP
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK, RSP_ERR, RSP_TMO, RSP_RD
  } resp_t;

  state_t            state_q, state_d;
  resp_t             kind_q, kind_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              rdyEn_q;

  logic       rxFire, isHex, isCR, isLF, isSP, lastByte;
  logic [3:0] nib;
  logic [4:0] hv;

  // Returns {valid, nibble} for an ASCII hex digit of either case.
  function automatic logic [4:0] hexVal(input logic [7:0] c);
    if (c >= "0" && c <= "9") return {1'b1, c[3:0]};
    else if ((c >= "A" && c <= "F") || (c >= "a" && c <= "f")) return {1'b1, c[3:0] + 4'd9};
    else return 5'd0;
  endfunction

  // Uppercase ASCII for one nibble.
  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign rx_ready = rdyEn_q && (state_q inside {IDLE, SEP1, ADDR, SEP2, DATA, DISCARD});
  assign rxFire   = rx_valid && rx_ready;
  assign hv       = hexVal(rx_data);
  assign isHex    = hv[4];
  assign nib      = hv[3:0];
  assign isCR     = (rx_data == 8'h0D);
  assign isLF     = (rx_data == 8'h0A);
  assign isSP     = (rx_data == 8'h20);

  assign tx_valid  = (state_q == RESP);
  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

  // Response byte selection; the read-data shift register always exposes the next nibble at its top.
  always_comb begin
    tx_data  = 8'h00;
    lastByte = 1'b0;
    if (state_q == RESP) begin
      unique case (kind_q)
        RSP_OK: begin
          lastByte = (idx_q == IW'(2));
          tx_data  = (idx_q == IW'(0)) ? "O" : (idx_q == IW'(1)) ? "K" : 8'h0A;
        end
        RSP_ERR: begin
          lastByte = (idx_q == IW'(3));
          tx_data  = (idx_q == IW'(0)) ? "E" : (idx_q == IW'(3)) ? 8'h0A : "R";
        end
        RSP_TMO: begin
          lastByte = (idx_q == IW'(3));
          tx_data  = (idx_q == IW'(0)) ? "T" : (idx_q == IW'(1)) ? "M" :
                     (idx_q == IW'(2)) ? "O" : 8'h0A;
        end
        default: begin
          lastByte = (idx_q == IW'(ND));
          tx_data  = lastByte ? 8'h0A : hexChar(rdata_q[DATA_W-1 -: 4]);
        end
      endcase
    end
  end

  // Parser, bus sequencing and response stepping; an LF that ends a malformed line jumps straight to ERR.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: if (rxFire && !isCR && !isLF) begin
        if (rx_data == "W" || rx_data == "R") begin
          we_d    = (rx_data == "W");
          state_d = SEP1;
        end else begin
          state_d = DISCARD;
        end
      end
      SEP1: if (rxFire && !isCR) begin
        if (isSP) begin
          state_d = ADDR;
          cnt_d   = '0;
          addr_d  = '0;
        end else if (isLF) begin
          state_d = RESP; kind_d = RSP_ERR; idx_d = '0;
        end else begin
          state_d = DISCARD;
        end
      end
      ADDR: if (rxFire && !isCR) begin
        if (isHex && cnt_q != CW'(NA)) begin
          addr_d = (addr_q << 4) | ADDR_W'(nib);
          cnt_d  = cnt_q + CW'(1);
        end else if (isSP && we_q && cnt_q != '0) begin
          state_d = SEP2;
        end else if (isLF && !we_q && cnt_q != '0) begin
          state_d = REQ; tmo_d = '0;
        end else if (isLF) begin
          state_d = RESP; kind_d = RSP_ERR; idx_d = '0;
        end else begin
          state_d = DISCARD;
        end
      end
      SEP2: if (rxFire && !isCR) begin
        if (isHex) begin
          state_d = DATA;
          wdata_d = DATA_W'(nib);
          cnt_d   = CW'(1);
        end else if (isLF) begin
          state_d = RESP; kind_d = RSP_ERR; idx_d = '0;
        end else begin
          state_d = DISCARD;
        end
      end
      DATA: if (rxFire && !isCR) begin
        if (isHex && cnt_q != CW'(ND)) begin
          wdata_d = (wdata_q << 4) | DATA_W'(nib);
          cnt_d   = cnt_q + CW'(1);
        end else if (isLF) begin
          state_d = REQ; tmo_d = '0;
        end else begin
          state_d = DISCARD;
        end
      end
      DISCARD: if (rxFire && isLF) begin
        state_d = RESP; kind_d = RSP_ERR; idx_d = '0;
      end
      REQ: begin
        if (bus_ack) begin
          rdata_d = bus_rdata;
          kind_d  = we_q ? RSP_OK : RSP_RD;
          idx_d   = '0;
          state_d = RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          kind_d  = RSP_TMO;
          idx_d   = '0;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: if (tx_ready) begin
        if (lastByte) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
          if (kind_q == RSP_RD) rdata_d = rdata_q << 4;
        end
      end
    endcase
  end

  // State register with synchronous reset; rx_ready is held off for one cycle after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q  <= RSP_OK;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      idx_q   <= '0;
      rdyEn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      rdyEn_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sock_line_responder.sv
// Testbench for sock_line_responder: table of command lines with expected
// responses and bus transactions, plus sequences for timeout, reset and streaming.
module tb_sock_line_responder;

  localparam int TIMEOUT = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int          ackDelay = 1;
  bit          lateAck = 0;
  bit          prevReq = 0;
  int          reqRun = 0;
  int          reqTotal = 0;
  int          reqCount = 0;
  int          busUnstable = 0;
  logic        capWe;
  logic [15:0] capAddr;
  logic [31:0] capWdata;
  bit          sawReq = 0;
  int          stableViol = 0;
  int          rxRdyViol = 0;

  typedef struct {
    string       line;
    string       resp;
    int          ackDelay;
    logic [31:0] rdata;
    int          expReqs;
    logic        expWe;
    logic [15:0] expAddr;
    logic [31:0] expWdata;
  } vec_t;

  vec_t vecs[15];

  sock_line_responder #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // Bus slave model: counts requests, checks stability, acks after ackDelay request cycles.
  always @(negedge clock) begin
    if (bus_req) begin
      if (!prevReq) begin
        reqCount++;
        capAddr  = bus_addr;
        capWe    = bus_we;
        capWdata = bus_wdata;
      end else if (bus_addr !== capAddr || bus_we !== capWe || bus_wdata !== capWdata) begin
        busUnstable++;
      end
      reqRun++;
      reqTotal++;
      bus_ack = (ackDelay > 0 && reqRun == ackDelay);
    end else begin
      reqRun  = 0;
      bus_ack = lateAck;
      lateAck = 0;
    end
    prevReq = bus_req;
  end

  function automatic string showStr(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) r = {r, "\\n"};
      else if (s[i] == 8'h0D) r = {r, "\\r"};
      else r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkStr(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, showStr(act), showStr(exp));
    end
  endtask

  task automatic sendLine(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bit done = 0;
      for (int k = 0; k < 2000 && !done; k++) begin
        @(negedge clock);
        rx_data  = s[i];
        rx_valid = 1'b1;
        if (bus_req) sawReq = 1;
        if (rx_ready) begin
          @(posedge clock);
          done = 1;
        end
      end
      if (!done) begin
        errors++;
        $display("[TB] FAIL send timeout: byte %0d of \"%s\" never accepted", i, showStr(s));
      end
    end
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic collect(input int nLines, input int mode, output string got);
    int   lines = 0;
    bit   prevHeld = 0;
    logic [7:0] prevData = 8'h00;
    got = "";
    for (int c = 0; c < 3000 && lines < nLines; c++) begin
      @(negedge clock);
      tx_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prevHeld && (!tx_valid || tx_data !== prevData)) stableViol++;
      if (tx_valid && rx_ready) rxRdyViol++;
      if (tx_valid && tx_ready) begin
        got = $sformatf("%s%c", got, tx_data);
        if (tx_data == 8'h0A) lines++;
      end
      prevHeld = tx_valid && !tx_ready;
      prevData = tx_data;
    end
  endtask

  task automatic applyStimulus(input int i);
    string got;
    ackDelay  = vecs[i].ackDelay;
    bus_rdata = vecs[i].rdata;
    reqCount  = 0;
    reqTotal  = 0;
    sawReq    = 0;
    fork
      sendLine(vecs[i].line);
      collect(1, 0, got);
    join
    checkStr($sformatf("vec%0d resp", i), got, vecs[i].resp);
    checkOutput($sformatf("vec%0d reqs", i), 32'(reqCount), 32'(vecs[i].expReqs));
    checkOutput($sformatf("vec%0d early req", i), 32'(sawReq), 32'd0);
    if (vecs[i].expReqs > 0) begin
      checkOutput($sformatf("vec%0d we", i), 32'(capWe), 32'(vecs[i].expWe));
      checkOutput($sformatf("vec%0d addr", i), 32'(capAddr), 32'(vecs[i].expAddr));
      checkOutput($sformatf("vec%0d req cycles", i), 32'(reqTotal), 32'(vecs[i].ackDelay));
      if (vecs[i].expWe) checkOutput($sformatf("vec%0d wdata", i), capWdata, vecs[i].expWdata);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    string got;
    bit    seen;

    vecs[0]  = '{"W 1A 0000BEEF\n", "OK\n",        3, 32'h0,        1, 1'b1, 16'h001A, 32'h0000BEEF};
    vecs[1]  = '{"R 001a\r\n",      "DEADBEEF\n",  1, 32'hDEADBEEF, 1, 1'b0, 16'h001A, 32'h0};
    vecs[2]  = '{"W 12345 1\n",     "ERR\n",       1, 32'h0,        0, 1'b0, 16'h0,    32'h0};
    vecs[3]  = '{"X\n",             "ERR\n",       1, 32'h0,        0, 1'b0, 16'h0,    32'h0};
    vecs[4]  = '{"R  1\n",          "ERR\n",       1, 32'h0,        0, 1'b0, 16'h0,    32'h0};
    vecs[5]  = '{"w 1 2\n",         "ERR\n",       1, 32'h0,        0, 1'b0, 16'h0,    32'h0};
    vecs[6]  = '{"R 1G\n",          "ERR\n",       1, 32'h0,        0, 1'b0, 16'h0,    32'h0};
    vecs[7]  = '{"W 5\n",           "ERR\n",       1, 32'h0,        0, 1'b0, 16'h0,    32'h0};
    vecs[8]  = '{"R 1 \n",          "ERR\n",       1, 32'h0,        0, 1'b0, 16'h0,    32'h0};
    vecs[9]  = '{"W 1 123456789\n", "ERR\n",       1, 32'h0,        0, 1'b0, 16'h0,    32'h0};
    vecs[10] = '{"W FFFF ffffffff\n", "OK\n",      2, 32'h0,        1, 1'b1, 16'hFFFF, 32'hFFFFFFFF};
    vecs[11] = '{"R\n",             "ERR\n",       1, 32'h0,        0, 1'b0, 16'h0,    32'h0};
    vecs[12] = '{"W 1 \n",          "ERR\n",       1, 32'h0,        0, 1'b0, 16'h0,    32'h0};
    vecs[13] = '{"R C\n",           "0123ABCD\n",  1, 32'h0123ABCD, 1, 1'b0, 16'h000C, 32'h0};
    vecs[14] = '{"W 3 7\r\r\n",     "OK\n",        1, 32'h0,        1, 1'b1, 16'h0003, 32'h00000007};

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("reset rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset bus_req", 32'(bus_req), 32'd0);
    checkOutput("reset bus_we", 32'(bus_we), 32'd0);
    checkOutput("reset bus_addr", 32'(bus_addr), 32'd0);
    checkOutput("reset bus_wdata", bus_wdata, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post-reset rx_ready", 32'(rx_ready), 32'd1);

    for (int i = 0; i < 15; i++) applyStimulus(i);

    // Empty line: no response, no bus activity
    reqCount = 0;
    sendLine("\n");
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (tx_valid || bus_req || busy) seen = 1;
    end
    checkOutput("empty line activity", 32'(seen), 32'd0);
    checkOutput("empty line reqs", 32'(reqCount), 32'd0);

    // Timeout followed by an ignored late ack
    ackDelay = -1;
    reqCount = 0;
    reqTotal = 0;
    fork
      sendLine("R 2\n");
      collect(1, 0, got);
    join
    checkStr("timeout resp", got, "TMO\n");
    checkOutput("timeout req cycles", 32'(reqTotal), 32'(TIMEOUT));
    checkOutput("timeout addr", 32'(capAddr), 32'h0002);
    lateAck = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (tx_valid || bus_req || busy) seen = 1;
    end
    checkOutput("late ack ignored", 32'(seen), 32'd0);

    // Reset in the middle of a read response
    ackDelay  = 1;
    bus_rdata = 32'hDEADBEEF;
    tx_ready  = 1'b0;
    sendLine("R 5\n");
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (tx_valid) seen = 1;
    end
    checkOutput("mid resp tx_valid", 32'(seen), 32'd1);
    tx_ready = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("mid resp 4th byte", 32'(tx_data), 32'h44);
    checkOutput("mid resp busy", 32'(busy), 32'd1);
    reset    = 1'b1;
    tx_ready = 1'b0;
    @(negedge clock);
    checkOutput("reset mid tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset mid tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset mid busy", 32'(busy), 32'd0);
    checkOutput("reset mid rx_ready", 32'(rx_ready), 32'd0);
    reset = 1'b0;
    seen  = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (tx_valid) seen = 1;
    end
    checkOutput("no resume after reset", 32'(seen), 32'd0);

    // Fresh read with random backpressure on tx_ready
    bus_rdata  = 32'h0;
    stableViol = 0;
    rxRdyViol  = 0;
    fork
      sendLine("R 0\n");
      collect(1, 1, got);
    join
    checkStr("backpressure resp", got, "00000000\n");
    checkOutput("backpressure stability", 32'(stableViol), 32'd0);
    checkOutput("rx_ready during resp", 32'(rxRdyViol), 32'd0);

    // Two commands streamed without gaps
    tx_ready  = 1'b1;
    bus_rdata = 32'h00000007;
    reqCount  = 0;
    fork
      sendLine("W 3 7\nR 3\n");
      collect(2, 0, got);
    join
    checkStr("back-to-back resp", got, "OK\n00000007\n");
    checkOutput("back-to-back reqs", 32'(reqCount), 32'd2);
    checkOutput("bus stability", 32'(busUnstable), 32'd0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sock_line_responder.md
Name: sock_line_responder

Overview:
- Synthesizable far end of the line-oriented text socket protocol: the simulation side writes one command line, then reads one response line.
- Consumes an 8-bit byte stream (valid/ready) carrying newline-terminated ASCII commands.
- Parses each line on the fly, issues one register-bus transaction, and emits exactly one newline-terminated ASCII response line on an outgoing byte stream.
- Sits between the byte-stream bridge and the register bus of the design under test.

Parameters:
- ADDR_W, 16, bus address width in bits; multiple of 4; hex digits NA = ADDR_W/4.
- DATA_W, 32, bus data width in bits; multiple of 4; hex digits ND = DATA_W/4.
- TIMEOUT, 255, maximum cycles bus_req stays high without bus_ack before abandoning the transaction.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  incoming ASCII byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- tx_data  out  8  outgoing ASCII byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  byte consumed when tx_valid && tx_ready.
- bus_req  out  1  transaction request; held until ack or timeout.
- bus_we  out  1  1 = write, 0 = read; stable while bus_req.
- bus_addr  out  ADDR_W  transaction address; stable while bus_req.
- bus_wdata  out  DATA_W  write data; stable while bus_req.
- bus_ack  in  1  single-cycle completion strobe.
- bus_rdata  in  DATA_W  read data; valid in the bus_ack cycle.
- busy  out  1  high from command accept through last response byte.

Behaviour:
Grammar, one command per line:
- Write: "W" SP addr SP data LF.
- Read: "R" SP addr LF.
- addr is 1..NA hex digits; data is 1..ND hex digits.
- Hex digits are case-insensitive. Fields are right-aligned and zero-extended.
- Command letter is case-sensitive. Exactly one SP between fields.
- CR (0x0D) is dropped anywhere and never affects parsing.
- An empty line (LF only) produces no response and no bus activity.

Responses:
- Write ack: "OK" LF.
- Read ack: exactly ND uppercase hex digits, MSB first, then LF.
- Malformed line: "ERR" LF. Causes include bad letter, missing or extra SP, non-hex digit, too many digits, empty field, or trailing characters.
- Bus timeout: "TMO" LF.
- A malformed line never asserts bus_req.

FSM states: IDLE, SEP1, ADDR, SEP2, DATA, DISCARD, REQ, RESP.
- IDLE: "W"/"R" latches bus_we, -> SEP1. LF stays in IDLE. Any other byte -> DISCARD with err=1.
- SEP1: SP -> ADDR with the digit count cleared. Anything else -> DISCARD.
- ADDR: hex shifts into the address register (shift left by 4) and increments the count.
  - Count already NA -> DISCARD.
  - SP on a write with count ≥ 1 -> SEP2.
  - LF on a read with count ≥ 1 -> REQ.
  - Any other byte -> DISCARD.
- DATA: same digit rules with limit ND; LF with count ≥ 1 -> REQ.
- DISCARD: swallows bytes until LF, then -> RESP with the "ERR" LF response.
- Address and data registers are cleared on entry to ADDR and DATA respectively.
- Bytes arriving after LF remain in the stream and are parsed as the next line.

Handshake and timing:
- rx_ready = 1 only in IDLE, SEP1, ADDR, SEP2, DATA and DISCARD.
- REQ: bus_req asserts the cycle after the terminating LF is accepted.
  - The timeout counter starts at 0 and increments each cycle.
  - bus_ack: deassert bus_req next cycle and capture bus_rdata in the ack cycle.
  - Counter reaches TIMEOUT without ack: drop bus_req and respond "TMO" LF.
  - A bus_ack arriving outside REQ is ignored.
- RESP: tx_valid is high, and tx_data is held stable until accepted.
  - Emits one byte per accepted handshake, with no gaps when tx_ready stays high.
  - After LF is accepted -> IDLE and busy=0 in the same cycle edge.
- tx_valid, once asserted, never drops before acceptance.

Reset:
- Synchronous, applied at a clock edge.
- Outputs on reset: rx_ready=0 (IDLE next cycle gives 1), tx_valid=0, tx_data=0x00, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, busy=0.
- Reset during REQ or RESP abandons the transaction immediately, and no partial response resumes afterwards.

Test Plan:
- Write: "W 1A 0000BEEF\n" with ack after 3 cycles -> one bus_req write, addr=0x001A, wdata=0x0000BEEF; tx emits "OK\n"; bus_req never asserted before the LF.
- Read: "r"-free line "R 001a\r\n" with bus_rdata=0xDEADBEEF at ack -> addr=0x001A, we=0; tx emits "DEADBEEF\n"; CR ignored.
- Errors:
  - "W 12345 1\n" (5 addr digits) -> "ERR\n", no bus_req.
  - "X\n" -> "ERR\n".
  - "R  1\n" (double space) -> "ERR\n".
  - "\n" alone -> no output.
- Timeout: "R 2\n", bus_ack held low -> bus_req high exactly TIMEOUT cycles, then "TMO\n"; a late ack is ignored.
- Backpressure: "R 0\n" with tx_ready toggled randomly -> each byte held stable until accepted, exactly "00000000\n", rx_ready=0 until the final LF is accepted.
- Reset and back-to-back:
  - Reset asserted mid-"DEADBEEF" response -> tx_valid=0 next cycle; "R 0\n" afterwards gets a full, fresh response.
  - Two commands streamed without gaps -> two responses, in order.
